change_dispenser: RTL

Coin-return sequencer for the vending machine: the payout counterpart to the coin-acceptance path. It takes a change amount in cents, pays it out greedily as quarters, dimes and nickels by stepping three coin-pusher servos one coin at a time, and reports the cents actually paid and any shortfall. It sits between the credit/purchase logic, which issues `start` with `amount`, and three `servo_controller` instances, which consume the `*_pos` outputs.

---
 rtl/change_dispenser.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy quarter/dime/nickel coin-return sequencer
module change_dispenser #(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int WIDTH       = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] amount,
    input  logic             quarter_empty,
    input  logic             dime_empty,
    input  logic             nickel_empty,
    output logic [1:0]       quarter_pos,
    output logic [1:0]       dime_pos,
    output logic [1:0]       nickel_pos,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dispensed,
    output logic [WIDTH-1:0] shortfall
);

    typedef enum logic [2:0] {IDLE, SELECT, PUSH, RETRACT, DONE} state_t;
    typedef enum logic [1:0] {COIN_NONE, COIN_QUARTER, COIN_DIME, COIN_NICKEL} coin_t;

    state_t           state, state_next;
    coin_t            coin, coin_next;
    logic [WIDTH-1:0] remaining;
    logic [WIDTH-1:0] coin_value;
    logic [31:0]      hold_cnt;
    logic             hold_last;

    assign hold_last = (hold_cnt == 32'(HOLD_CYCLES - 1));

    // Cent value of the coin currently being pushed
    always_comb begin
        coin_value = '0;
        case (coin)
            COIN_QUARTER: coin_value = WIDTH'(25);
            COIN_DIME:    coin_value = WIDTH'(10);
            COIN_NICKEL:  coin_value = WIDTH'(5);
            default:      coin_value = '0;
        endcase
    end

    // Next-state logic; the greedy coin choice and tube sensing happen only in SELECT
    always_comb begin
        state_next = state;
        coin_next  = coin;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SELECT;
                end
            end
            SELECT: begin
                if (remaining >= WIDTH'(25) && !quarter_empty) begin
                    coin_next  = COIN_QUARTER;
                    state_next = PUSH;
                end else if (remaining >= WIDTH'(10) && !dime_empty) begin
                    coin_next  = COIN_DIME;
                    state_next = PUSH;
                end else if (remaining >= WIDTH'(5) && !nickel_empty) begin
                    coin_next  = COIN_NICKEL;
                    state_next = PUSH;
                end else begin
                    coin_next  = COIN_NONE;
                    state_next = DONE;
                end
            end
            PUSH: begin
                if (hold_last) begin
                    state_next = RETRACT;
                end
            end
            RETRACT: begin
                if (hold_last) begin
                    coin_next  = COIN_NONE;
                    state_next = SELECT;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                coin_next  = COIN_NONE;
                state_next = IDLE;
            end
        endcase
    end

    // State and selected-coin registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            coin  <= COIN_NONE;
        end else begin
            state <= state_next;
            coin  <= coin_next;
        end
    end

    // Hold counter times both the extended and the retracted phase of each coin
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_cnt <= '0;
        end else if ((state == PUSH || state == RETRACT) && !hold_last) begin
            hold_cnt <= hold_cnt + 32'd1;
        end else begin
            hold_cnt <= '0;
        end
    end

    // Payout bookkeeping; dispensed+remaining always equals the latched amount
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            remaining <= '0;
            dispensed <= '0;
            shortfall <= '0;
        end else begin
            if (state == IDLE && start) begin
                remaining <= amount;
                dispensed <= '0;
                shortfall <= '0;
            end
            if (state == PUSH && hold_last) begin
                remaining <= remaining - coin_value;
                dispensed <= dispensed + coin_value;
            end
            if (state == SELECT && state_next == DONE) begin
                shortfall <= remaining;
            end
        end
    end

    // Servo codes decode straight from state so reset retracts every pusher at once
    assign quarter_pos = (state == PUSH && coin == COIN_QUARTER) ? 2'b01 : 2'b00;
    assign dime_pos    = (state == PUSH && coin == COIN_DIME)    ? 2'b01 : 2'b00;
    assign nickel_pos  = (state == PUSH && coin == COIN_NICKEL)  ? 2'b01 : 2'b00;
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);

endmodule
